// File: rtl/inta_sequencer_if.sv
// Handshake/bus bundle between the interrupt sequencer and its surroundings.
// The aeoi_mode signal exists only when INTA_AEOI_EN is defined.
interface inta_sequencer_if;
  logic [7:0] irr;
  logic       inta_n;
  logic [4:0] icw2_vec;
  logic       eoi;
`ifdef INTA_AEOI_EN
  logic       aeoi_mode;
`endif
  logic       int_o;
  logic [7:0] isr;
  logic [7:0] irr_clr;
  logic [7:0] data_out;
  logic       data_oe;
  logic [2:0] cur_level;

  // Environment side: request register, control logic and CPU.
  modport master (
`ifdef INTA_AEOI_EN
    output aeoi_mode,
`endif
    output irr, inta_n, icw2_vec, eoi,
    input  int_o, isr, irr_clr, data_out, data_oe, cur_level
  );

  // Sequencer side.
  modport slave (
`ifdef INTA_AEOI_EN
    input  aeoi_mode,
`endif
    input  irr, inta_n, icw2_vec, eoi,
    output int_o, isr, irr_clr, data_out, data_oe, cur_level
  );
endinterface

// File: rtl/inta_sequencer.sv
// 8-level priority resolver and two-pulse INTA vector sequencer.
// Optional auto-EOI is enabled by defining INTA_AEOI_EN (adds aeoi_mode).
module inta_sequencer (
  input  logic             clk,
  input  logic             rst_n,
  inta_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK1 = 2'd2,
    S_ACK2 = 2'd3
  } state_t;

  state_t     state_q, state_nx;
  logic       inta_q;
  logic       int_q, int_nx;
  logic [7:0] isr_q, isr_nx;
  logic [7:0] irr_clr_q, irr_clr_nx;
  logic [7:0] dout_q, dout_nx;
  logic       doe_q, doe_nx;
  logic [2:0] lvl_q, lvl_nx;
  logic       spur_q, spur_nx;

  logic       inta_fall, inta_rise;
  logic [7:0] isr_cum;
  logic [7:0] elig;
  logic       any_elig;
  logic [2:0] hi_lvl;
  logic [7:0] isr_top;
  logic [7:0] isr_set, isr_aeoi_clr;
  logic       aeoi_on;

`ifdef INTA_AEOI_EN
  assign aeoi_on = bus.aeoi_mode;
`else
  assign aeoi_on = 1'b0;
`endif

  assign inta_fall = inta_q & ~bus.inta_n;
  assign inta_rise = ~inta_q & bus.inta_n;

  // isr_cum[i] is set when any isr bit of equal or higher priority is set,
  // which blocks request i; isr_top isolates the highest-priority isr bit.
  always_comb begin
    isr_cum[0] = isr_q[0];
    for (int i = 1; i < 8; i++) isr_cum[i] = isr_cum[i-1] | isr_q[i];
  end

  assign elig     = bus.irr & ~isr_cum;
  assign any_elig = |elig;
  assign isr_top  = isr_q & ~{isr_cum[6:0], 1'b0};

  always_comb begin
    hi_lvl = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (elig[i]) hi_lvl = 3'(i);
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx     = state_q;
    int_nx       = int_q;
    lvl_nx       = lvl_q;
    spur_nx      = spur_q;
    irr_clr_nx   = 8'h00;
    dout_nx      = dout_q;
    doe_nx       = doe_q;
    isr_set      = 8'h00;
    isr_aeoi_clr = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          state_nx = S_REQ;
          int_nx   = 1'b1;
          lvl_nx   = hi_lvl;
        end
      end

      S_REQ: begin
        if (inta_fall) begin
          state_nx = S_ACK1;
          if (any_elig) begin
            lvl_nx     = hi_lvl;
            isr_set    = 8'h01 << hi_lvl;
            irr_clr_nx = 8'h01 << hi_lvl;
            spur_nx    = 1'b0;
          end else begin
            lvl_nx  = 3'd7;
            spur_nx = 1'b1;
          end
        end else if (any_elig) begin
          lvl_nx = hi_lvl;
        end
      end

      S_ACK1: begin
        if (inta_rise) state_nx = S_ACK2;
      end

      S_ACK2: begin
        // doe_q distinguishes waiting for the second pulse from driving it.
        if (!doe_q && inta_fall) begin
          doe_nx  = 1'b1;
          dout_nx = {bus.icw2_vec, lvl_q};
          int_nx  = 1'b0;
        end else if (doe_q && inta_rise) begin
          doe_nx   = 1'b0;
          dout_nx  = 8'h00;
          state_nx = S_IDLE;
          if (aeoi_on && !spur_q) isr_aeoi_clr = 8'h01 << lvl_q;
        end
      end

      default: state_nx = S_IDLE;
    endcase

    // EOI acts on the pre-set isr value, so a same-cycle set survives.
    isr_nx = (isr_q & ~(bus.eoi ? isr_top : 8'h00) & ~isr_aeoi_clr) | isr_set;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      inta_q    <= 1'b1;
      int_q     <= 1'b0;
      isr_q     <= 8'h00;
      irr_clr_q <= 8'h00;
      dout_q    <= 8'h00;
      doe_q     <= 1'b0;
      lvl_q     <= 3'd0;
      spur_q    <= 1'b0;
    end else begin
      state_q   <= state_nx;
      inta_q    <= bus.inta_n;
      int_q     <= int_nx;
      isr_q     <= isr_nx;
      irr_clr_q <= irr_clr_nx;
      dout_q    <= dout_nx;
      doe_q     <= doe_nx;
      lvl_q     <= lvl_nx;
      spur_q    <= spur_nx;
    end
  end

  assign bus.int_o     = int_q;
  assign bus.isr       = isr_q;
  assign bus.irr_clr   = irr_clr_q;
  assign bus.data_out  = dout_q;
  assign bus.data_oe   = doe_q;
  assign bus.cur_level = lvl_q;

  a_irr_clr_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(irr_clr_q));
  a_oe_only_ack2: assert property (@(posedge clk) disable iff (!rst_n)
    doe_q |-> (state_q == S_ACK2));

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: table of acknowledge scenarios plus
// hand-written nesting, EOI-collision, reset and auto-EOI sequences.
module tb_inta_sequencer;

  logic clk;
  logic rst_n;
  inta_sequencer_if bus ();

  inta_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irr_a;       // request that raises int_o
    logic [7:0] irr_b;       // request just before the first INTA
    logic [4:0] vec;
    bit         eoi_ack;     // pulse eoi in the same cycle as the ACK1 set
    bit         rst_ack2;    // assert reset while the vector is driven
    logic [2:0] exp_lvl;
    logic [7:0] exp_clr;
    logic [7:0] exp_isr;     // after first falling edge
    logic [7:0] exp_isr_end; // after second rising edge
    logic [7:0] exp_data;
  } ack_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_q[$];
  logic       prev_oe = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every vector the DUT starts driving must match the queue head.
  always @(negedge clk) begin
    if (bus.data_oe === 1'b1 && prev_oe !== 1'b1) begin
      if (sb_q.size() == 0) check("unexpected_vector_oe", {7'b0, bus.data_oe}, 8'h00);
      else check("vector", bus.data_out, sb_q.pop_front());
    end
    prev_oe <= bus.data_oe;
  end

  task automatic run_ack(input ack_t v);
    int n;
    @(negedge clk);
    bus.irr = v.irr_a;
    n = 0;
    while (bus.int_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("int_o_raise", {7'b0, bus.int_o}, 8'h01);
    if (bus.int_o !== 1'b1) begin
      bus.irr = 8'h00;
      return;
    end
    bus.irr = v.irr_b;
    @(negedge clk);
    sb_q.push_back(v.exp_data);
    bus.inta_n = 1'b0;
    bus.eoi    = v.eoi_ack;
    @(negedge clk);
    bus.eoi = 1'b0;
    check("ack1_irr_clr", bus.irr_clr, v.exp_clr);
    check("ack1_isr", bus.isr, v.exp_isr);
    check("ack1_level", {5'b0, bus.cur_level}, {5'b0, v.exp_lvl});
    check("ack1_oe", {7'b0, bus.data_oe}, 8'h00);
    bus.irr = 8'hFF;  // must not disturb the frozen level
    @(negedge clk);
    check("irr_clr_pulse_end", bus.irr_clr, 8'h00);
    bus.inta_n = 1'b1;
    @(negedge clk);
    check("ack2_wait_oe", {7'b0, bus.data_oe}, 8'h00);
    bus.inta_n = 1'b0;
    @(negedge clk);
    check("ack2_oe", {7'b0, bus.data_oe}, 8'h01);
    check("ack2_int_o", {7'b0, bus.int_o}, 8'h00);
    if (v.rst_ack2) begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_oe", {7'b0, bus.data_oe}, 8'h00);
      check("rst_data", bus.data_out, 8'h00);
      check("rst_isr", bus.isr, 8'h00);
      check("rst_int_o", {7'b0, bus.int_o}, 8'h00);
      check("rst_level", {5'b0, bus.cur_level}, 8'h00);
      @(negedge clk);
      bus.inta_n = 1'b1;
      bus.irr    = 8'h00;
      rst_n      = 1'b1;
      return;
    end
    @(negedge clk);
    check("ack2_oe_hold", {7'b0, bus.data_oe}, 8'h01);
    bus.inta_n = 1'b1;
    @(negedge clk);
    bus.irr = 8'h00;
    check("end_oe", {7'b0, bus.data_oe}, 8'h00);
    check("end_data", bus.data_out, 8'h00);
    check("end_isr", bus.isr, v.exp_isr_end);
    @(negedge clk);
  endtask

  task automatic eoi_pulse();
    @(negedge clk);
    bus.eoi = 1'b1;
    @(negedge clk);
    bus.eoi = 1'b0;
  endtask

  task automatic clear_isr();
    repeat (8) eoi_pulse();
    check("isr_cleared", bus.isr, 8'h00);
  endtask

  task automatic idle_inta_pulse(input string name);
    @(negedge clk);
    bus.inta_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check(name, {6'b0, bus.int_o, bus.data_oe}, 8'h00);
    end
    bus.inta_n = 1'b1;
    @(negedge clk);
  endtask

  ack_t tbl[5];

  initial begin
    //            irr_a  irr_b  vec    eoi rst lvl clr    isr    isr_end data
    tbl[0] = '{8'h08, 8'h08, 5'h11, 0, 0, 3, 8'h08, 8'h08, 8'h08, 8'h8B};
    tbl[1] = '{8'h04, 8'h00, 5'h1F, 0, 0, 7, 8'h00, 8'h00, 8'h00, 8'hFF};
    tbl[2] = '{8'h40, 8'h41, 5'h02, 0, 0, 0, 8'h01, 8'h01, 8'h01, 8'h10};
    tbl[3] = '{8'h80, 8'h80, 5'h00, 0, 0, 7, 8'h80, 8'h80, 8'h80, 8'h07};
    tbl[4] = '{8'hFF, 8'hFF, 5'h0A, 0, 0, 0, 8'h01, 8'h01, 8'h01, 8'h50};

    rst_n        = 1'b0;
    bus.irr      = 8'h00;
    bus.inta_n   = 1'b1;
    bus.icw2_vec = 5'h00;
    bus.eoi      = 1'b0;
`ifdef INTA_AEOI_EN
    bus.aeoi_mode = 1'b0;
`endif
    #3;
    check("reset_int_o", {7'b0, bus.int_o}, 8'h00);
    check("reset_isr", bus.isr, 8'h00);
    check("reset_irr_clr", bus.irr_clr, 8'h00);
    check("reset_data", bus.data_out, 8'h00);
    check("reset_oe", {7'b0, bus.data_oe}, 8'h00);
    check("reset_level", {5'b0, bus.cur_level}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // INTA while idle is ignored.
    idle_inta_pulse("idle_inta");
    check("idle_isr", bus.isr, 8'h00);
    check("idle_level", {5'b0, bus.cur_level}, 8'h00);

    for (int i = 0; i < 5; i++) begin
      bus.icw2_vec = tbl[i].vec;
      run_ack(tbl[i]);
      clear_isr();
    end

    // Nesting: a lower-priority request is blocked, a higher one nests.
    bus.icw2_vec = 5'h11;
    run_ack('{8'h08, 8'h08, 5'h11, 0, 0, 3, 8'h08, 8'h08, 8'h08, 8'h8B});
    @(negedge clk);
    bus.irr = 8'h20;
    repeat (4) @(negedge clk);
    check("nest_blocked_int_o", {7'b0, bus.int_o}, 8'h00);
    run_ack('{8'h02, 8'h02, 5'h11, 0, 0, 1, 8'h02, 8'h0A, 8'h0A, 8'h89});
    eoi_pulse();
    check("nest_eoi", bus.isr, 8'h08);
    clear_isr();

    // EOI colliding with the ACK1 set.
    run_ack('{8'h10, 8'h10, 5'h11, 0, 0, 4, 8'h10, 8'h10, 8'h10, 8'h8C});
    run_ack('{8'h01, 8'h01, 5'h11, 1, 0, 0, 8'h01, 8'h01, 8'h01, 8'h88});
    clear_isr();

`ifdef INTA_AEOI_EN
    bus.aeoi_mode = 1'b1;
    run_ack('{8'h80, 8'h80, 5'h00, 0, 0, 7, 8'h80, 8'h80, 8'h00, 8'h07});
    bus.aeoi_mode = 1'b0;
    run_ack('{8'h10, 8'h10, 5'h11, 0, 0, 4, 8'h10, 8'h10, 8'h10, 8'h8C});
    bus.aeoi_mode = 1'b1;
    run_ack('{8'h01, 8'h01, 5'h11, 1, 0, 0, 8'h01, 8'h01, 8'h00, 8'h88});
    bus.aeoi_mode = 1'b0;
    clear_isr();
`endif

    // Reset while the vector is on the bus, then stray INTA pulses.
    bus.icw2_vec = 5'h03;
    run_ack('{8'h02, 8'h02, 5'h03, 0, 1, 1, 8'h02, 8'h02, 8'h02, 8'h19});
    idle_inta_pulse("post_rst_inta1");
    idle_inta_pulse("post_rst_inta2");
    check("post_rst_isr", bus.isr, 8'h00);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 8'(sb_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 The block SHALL have no parameters; it serves exactly 8 levels (IR0 highest, IR7 lowest).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 irr  input  8  pending, already-masked requests from the request register.
REQ-006 inta_n  input  1  CPU interrupt acknowledge, active low, synchronous to clk.
REQ-007 icw2_vec  input  5  vector base T7..T3.
REQ-008 eoi  input  1  one-cycle non-specific EOI pulse from control logic.
REQ-009 aeoi_mode  input  1  auto-EOI enable; present only when INTA_AEOI_EN is defined.
REQ-010 int_o  output  1  interrupt request to CPU.
REQ-011 isr  output  8  in-service register.
REQ-012 irr_clr  output  8  one-cycle one-hot pulse clearing the acknowledged request.
REQ-013 data_out  output  8  vector byte.
REQ-014 data_oe  output  1  data bus drive enable.
REQ-015 cur_level  output  3  level latched for the current acknowledge cycle.

Function
REQ-016 The block SHALL implement a four-state FSM: IDLE, REQ, ACK1, ACK2.
REQ-017 Eligibility: an irr bit SHALL be eligible only if its priority is strictly higher than the highest set isr bit (all bits are eligible when isr is zero).
REQ-018 In IDLE, when any bit is eligible, the block SHALL go to REQ and assert int_o on the next clock edge.
REQ-019 In REQ, cur_level SHALL track the highest eligible bit every cycle until the first inta_n falling edge.
REQ-020 inta_n edges SHALL be detected against a registered copy of inta_n, so each edge costs 1 cycle of latency.
REQ-021 On the first falling edge with an eligible bit present, the block SHALL freeze cur_level, set isr[cur_level], pulse irr_clr[cur_level] for 1 cycle, and enter ACK1.
REQ-022 On the first falling edge with no eligible bit present (spurious), the block SHALL set cur_level=7, leave isr and irr_clr unchanged, and enter ACK1.
REQ-023 data_oe SHALL stay 0 throughout the first INTA pulse.
REQ-024 On the rising edge of inta_n in ACK1, the block SHALL enter ACK2.
REQ-025 On the second falling edge, the block SHALL drive data_out={icw2_vec,cur_level}, hold data_oe=1 while inta_n stays low, and deassert int_o.
REQ-026 On the second rising edge, the block SHALL drive data_oe=0 and data_out=0, clear isr[cur_level] if AEOI is active and the cycle was not spurious, and return to IDLE.
REQ-027 eoi SHALL clear the highest-priority set isr bit; an eoi with isr zero SHALL have no effect.
REQ-028 If eoi and the ACK1 set occur in the same cycle, eoi SHALL clear the highest bit of the pre-set isr value and the new bit SHALL still be set.
REQ-029 An inta_n falling edge in IDLE SHALL be ignored: no outputs change.
REQ-030 irr changes after ACK1 entry SHALL NOT alter cur_level.
REQ-031 A new request SHALL be raised only after returning to IDLE, with a minimum of 1 idle cycle between acknowledge sequences.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE, int_o=0, isr=0, irr_clr=0, data_out=0, data_oe=0, cur_level=0, and the registered inta_n=1.
REQ-033 A reset asserted mid-sequence SHALL abandon the sequence; no vector is driven afterwards, and any subsequent inta_n pulses are ignored until a new request is raised.

Configuration
REQ-034 With INTA_AEOI_EN defined, the aeoi_mode port SHALL exist, and aeoi_mode=1 SHALL clear the served isr bit at the second rising edge of inta_n.
REQ-035 Without INTA_AEOI_EN, the aeoi_mode port SHALL be absent and isr bits SHALL clear only via eoi.

Verification
REQ-036 Normal acknowledge: irr=0x08, icw2_vec=0x11, two INTA pulses -> int_o=1, irr_clr=0x08 pulse, isr=0x08, data_out=0x8B with data_oe=1 only during the second pulse.
REQ-037 Nesting: isr=0x08, then irr=0x20 -> int_o stays 0; then irr=0x02 -> acknowledge gives isr=0x0A; eoi -> isr=0x08.
REQ-038 Spurious: irr=0x04 raises int_o, then irr=0x00 before the first INTA -> vector {icw2_vec,3'b111}, isr unchanged, no irr_clr pulse.
REQ-039 Priority tracking: irr=0x40 then 0x41 before the first INTA -> cur_level=0, isr=0x01.
REQ-040 Reset mid-ACK2: rst_n low while data_oe=1 -> data_oe=0 and isr=0 immediately; following inta_n pulses produce no output.
REQ-041 AEOI (INTA_AEOI_EN defined, aeoi_mode=1): irr=0x80, acknowledge -> isr returns to 0x00 after the second rising edge; simultaneous eoi plus ACK1 with isr=0x10 and irr=0x01 -> isr=0x01.
